// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter (IF / DM sharing one single-port macro).
package mem_arbiter_pkg;

    localparam int unsigned LAT_CNT_W = 2;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned LANES     = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_e;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

    typedef struct packed {
        logic [LANES-1:0]  we;
        logic [WORD_W-1:0] wdata;
    } lane_t;

endpackage

// File: rtl/mem_arbiter_lanes.sv
// Byte-lane steering for DM stores: size/offset -> little-endian byte enables and replicated data.
module mem_arbiter_lanes
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] wdata,
    input  logic              we,
    output lane_t             lane
);

    always_comb begin
        lane.we    = 4'b0000;
        lane.wdata = wdata;
        case (size)
            SZ_HALF: begin
                lane.wdata = {2{wdata[15:0]}};
                lane.we    = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            SZ_BYTE: begin
                lane.wdata = {4{wdata[7:0]}};
                lane.we    = 4'b0001 << addr_lo;
            end
            SZ_WORD: lane.we = 4'b1111;
            default: lane.we = 4'b1111;
        endcase
        // loads and refused sc must not touch memory
        if (!we) begin
            lane.we = 4'b0000;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between fetch (IF) and load/store (DM) with fixed MEM_LAT.
// Optional ll/sc link tracking is built when MEM_ARBITER_LLSC_EN is defined.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [1:0]        dm_size,
    input  logic              dm_ll,
    input  logic              dm_sc,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_sc_ok,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned           WA_W     = ADDR_W - 2;
    localparam logic [LAT_CNT_W-1:0]  LAT_LOAD = LAT_CNT_W'(MEM_LAT - 1);

    state_e                state_q, state_d;
    logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  last_q;
    logic                  gnt_if, gnt_dm;
    logic                  if_done, dm_done;
    logic                  sc_pass, store_ok;
    lane_t                 lane;
    logic [DATA_W-1:0]     if_rdata_q, dm_rdata_q;
    logic                  sc_ok_q;
    logic                  unused_bits;

    // lone requester wins; a tie goes to the port not served last (grants gated off during reset)
    always_comb begin
        gnt_if = 1'b0;
        gnt_dm = 1'b0;
        if (state_q == IDLE && rst_n) begin
            gnt_dm = dm_req && (!if_req || last_q == GNT_IF);
            gnt_if = if_req && (!dm_req || last_q == GNT_DM);
        end
    end

    assign if_done  = (state_q == BUSY_IF) && (cnt_q == '0);
    assign dm_done  = (state_q == BUSY_DM) && (cnt_q == '0);
    assign store_ok = dm_we && sc_pass;

    mem_arbiter_lanes u_lanes (
        .size    (dm_size),
        .addr_lo (dm_addr[1:0]),
        .wdata   (dm_wdata),
        .we      (store_ok),
        .lane    (lane)
    );

    // state register, latency counter and round-robin memory
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= GNT_IF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (gnt_dm) begin
                last_q <= GNT_DM;
            end else if (gnt_if) begin
                last_q <= GNT_IF;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (gnt_dm) begin
                    state_d = BUSY_DM;
                    cnt_d   = LAT_LOAD;
                end else if (gnt_if) begin
                    state_d = BUSY_IF;
                    cnt_d   = LAT_LOAD;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // grant-cycle strobe; read data passes through in the ack cycle and is held afterwards
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_dm) begin
            mem_en    = 1'b1;
            mem_we    = lane.we;
            mem_addr  = dm_addr[ADDR_W-1:2];
            mem_wdata = lane.wdata;
        end else if (gnt_if) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr[ADDR_W-1:2];
        end
        if_ack   = if_done;
        dm_ack   = dm_done;
        if_rdata = if_done ? mem_rdata : if_rdata_q;
        dm_rdata = dm_done ? mem_rdata : dm_rdata_q;
        dm_sc_ok = dm_done && sc_ok_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            sc_ok_q    <= 1'b0;
        end else begin
            if (if_done) begin
                if_rdata_q <= mem_rdata;
            end
            if (dm_done) begin
                dm_rdata_q <= mem_rdata;
            end
            if (gnt_dm) begin
                sc_ok_q <= store_ok;
            end
        end
    end

`ifdef MEM_ARBITER_LLSC_EN
    logic            link_valid_q, txn_ll_q, txn_clr_q, link_hit;
    logic [WA_W-1:0] link_addr_q, txn_addr_q;

    assign link_hit    = link_valid_q && (link_addr_q == dm_addr[ADDR_W-1:2]);
    assign sc_pass     = !dm_sc || link_hit;
    assign unused_bits = ^if_addr[1:0];

    // transaction attributes are latched at grant since DM inputs may drop before ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
            txn_ll_q     <= 1'b0;
            txn_clr_q    <= 1'b0;
            txn_addr_q   <= '0;
        end else begin
            if (gnt_dm) begin
                txn_ll_q   <= dm_ll && !dm_we;
                txn_clr_q  <= dm_we && (dm_sc || link_hit);
                txn_addr_q <= dm_addr[ADDR_W-1:2];
            end
            if (dm_done) begin
                if (txn_ll_q) begin
                    link_valid_q <= 1'b1;
                    link_addr_q  <= txn_addr_q;
                end else if (txn_clr_q) begin
                    link_valid_q <= 1'b0;
                end
            end
        end
    end
`else
    assign sc_pass     = 1'b1;
    assign unused_bits = ^{if_addr[1:0], dm_ll, dm_sc};
`endif

endmodule
